player_turn_queue: RTL and testbench
====================================

PLAYER_TURN_QUEUE -- requirements
Module: player_turn_queue

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 3, number of independent players.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, turn commands buffered per player (power of two, >=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, stable-level cycles before a key change is accepted (used only under REQ-024).
REQ-004 SHALL have port CLOCK_50  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port game_tick  input  1  one-cycle pulse per game step.
REQ-007 SHALL have port run  input  1  high while the round is in progress.
REQ-008 SHALL have port key_left  input  NUM_PLAYERS  per-player left-key level, 1 = held.
REQ-009 SHALL have port key_right  input  NUM_PLAYERS  per-player right-key level, 1 = held.
REQ-010 SHALL have port turn  output  2*NUM_PLAYERS  per-player command; player p at bits [2p+1:2p]; 01 = right, 10 = left, 00 = straight.
REQ-011 SHALL have port overflow  output  NUM_PLAYERS  sticky per-player flag, set when a command is dropped.

Function
REQ-012 SHALL register each key level and detect a press as a 0->1 transition of the registered level.
REQ-013 SHALL push RIGHT on a right press alone, LEFT on a left press alone, and nothing when both press in the same cycle.
REQ-014 SHALL pop one entry per player on every game_tick while run=1 and drive it on that player's turn field in the next cycle.
REQ-015 SHALL drive 00 on a player's field after a game_tick that finds that player's queue empty.
REQ-016 SHALL hold each turn field unchanged between game_ticks.
REQ-017 SHALL, on a push and a pop in the same cycle, do both, leaving occupancy unchanged; when the queue is empty, the pushed command is not popped until the next game_tick.
REQ-018 SHALL discard a push to a full queue that is not popped in the same cycle, and set that player's overflow bit.
REQ-019 SHALL, while run=0, flush all queues to empty, force turn to 0, and ignore presses; overflow is kept.
REQ-020 SHALL ignore game_tick while run=0.
REQ-021 SHALL wrap read and write pointers modulo QUEUE_DEPTH and keep a count of width clog2(QUEUE_DEPTH)+1.

Reset
REQ-022 SHALL, when reset=1 at a rising edge, empty all queues, clear turn, overflow and registered key levels to 0, and zero the debounce counters; this applies mid-operation too.
REQ-023 SHALL not detect a press in the first cycle after reset deasserts for a key that is held through reset.

Configuration
REQ-024 SHALL, with macro TURN_DEBOUNCE_EN defined, accept a key level change only after the raw input has differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles, using one counter per key; without it, the raw level is registered directly.

Structure
REQ-025 SHALL take TURN_NONE=2'b00, TURN_RIGHT=2'b01, TURN_LEFT=2'b10 and the default NUM_PLAYERS from shared package lightbike_pkg.
REQ-026 SHALL implement the per-player buffer as sub-module turn_fifo (push, pop, flush, din, dout, full, empty), instantiated NUM_PLAYERS times.

Verification
REQ-027 SHALL cover: run=1, key_right[0] pulsed once, then game_tick -> turn[1:0]=01 the cycle after the tick; the next tick -> 00.
REQ-028 SHALL cover: key_left[1] pressed 3 times between ticks with QUEUE_DEPTH=2 -> ticks yield 10, 10, 00, and overflow[1]=1.
REQ-029 SHALL cover: key_left[2] and key_right[2] rising in the same cycle -> no push; the next tick gives turn[5:4]=00.
REQ-030 SHALL cover: queue full and a press coinciding with game_tick -> no overflow; two more ticks drain the queue in order.
REQ-031 SHALL cover: reset asserted while queues are non-empty with a key held -> turn=0, overflow=0, and no press is recognised after release of reset until the key is released and re-pressed.
REQ-032 SHALL cover, with TURN_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 3-cycle pulse -> no push; a 5-cycle pulse -> exactly one push.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared lightbike definitions: turn command encoding and default player count.
package lightbike_pkg;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'b00,
        TURN_RIGHT = 2'b01,
        TURN_LEFT  = 2'b10
    } turn_e;

    localparam int unsigned DEFAULT_NUM_PLAYERS = 3;

    // A simultaneous left+right press cancels out to no command.
    function automatic logic [1:0] encode_turn(input logic left, input logic right);
        case ({left, right})
            2'b10:   return TURN_LEFT;
            2'b01:   return TURN_RIGHT;
            default: return TURN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/turn_fifo.sv
// Small per-player command FIFO with flush; a push to a full queue only lands if a pop
// frees a slot in the same cycle.
module turn_fifo #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic       full,
    output logic       empty
);

    logic [1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLOCK_50) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/player_turn_queue.sv
// Per-player turn command queue: key presses become queued turns, popped on game_tick.
// Optional key debouncing is enabled with macro TURN_DEBOUNCE_EN.
module player_turn_queue
    import lightbike_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = DEFAULT_NUM_PLAYERS,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     game_tick,
    input  logic                     run,
    input  logic [NUM_PLAYERS-1:0]   key_left,
    input  logic [NUM_PLAYERS-1:0]   key_right,
    output logic [2*NUM_PLAYERS-1:0] turn,
    output logic [NUM_PLAYERS-1:0]   overflow
);

    localparam int unsigned NK = 2 * NUM_PLAYERS;

    // Key k < NUM_PLAYERS is a left key, k >= NUM_PLAYERS the matching right key.
    logic [NK-1:0] key_raw, level_q, level_prev_q, held_q, press;
    logic          pop;

    assign key_raw = {key_right, key_left};
    assign pop     = run && game_tick;

`ifdef TURN_DEBOUNCE_EN
    logic [15:0] db_cnt_q [NK];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level_q <= '0;
            for (int k = 0; k < NK; k++) db_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                if (key_raw[k] != level_q[k]) begin
                    if (db_cnt_q[k] + 16'd1 >= DEBOUNCE_CYCLES) begin
                        level_q[k]  <= key_raw[k];
                        db_cnt_q[k] <= '0;
                    end else begin
                        db_cnt_q[k] <= db_cnt_q[k] + 16'd1;
                    end
                end else begin
                    db_cnt_q[k] <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge CLOCK_50) begin
        if (reset) level_q <= '0;
        else       level_q <= key_raw;
    end
`endif

    // held_q masks keys that were down during reset until they are seen released.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level_prev_q <= '0;
            held_q       <= '1;
        end else begin
            level_prev_q <= level_q;
            held_q       <= held_q & key_raw;
        end
    end

    assign press = level_q & ~level_prev_q & ~held_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic       push, full, empty;
        logic [1:0] din, dout, turn_q;
        logic       ovf_q;

        assign din  = encode_turn(press[p], press[NUM_PLAYERS+p]);
        assign push = run && (din != TURN_NONE);

        turn_fifo #(
            .DEPTH(QUEUE_DEPTH)
        ) u_fifo (
            .CLOCK_50(CLOCK_50),
            .reset   (reset),
            .flush   (!run),
            .push    (push),
            .pop     (pop),
            .din     (din),
            .dout    (dout),
            .full    (full),
            .empty   (empty)
        );

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                turn_q <= TURN_NONE;
                ovf_q  <= 1'b0;
            end else begin
                if (!run)          turn_q <= TURN_NONE;
                else if (game_tick) turn_q <= empty ? TURN_NONE : dout;
                // A full queue is never empty, so a pop here always frees a slot.
                if (push && full && !pop) ovf_q <= 1'b1;
            end
        end

        assign turn[2*p +: 2] = turn_q;
        assign overflow[p]    = ovf_q;
    end

endmodule

// File: tb/tb_player_turn_queue.sv
// Scoreboard bench for player_turn_queue; adapts key hold times when TURN_DEBOUNCE_EN is set.
module tb_player_turn_queue;

    localparam int unsigned NP = 3;
    localparam int unsigned QD = 2;
`ifdef TURN_DEBOUNCE_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam logic [1:0] T_NONE  = 2'b00;
    localparam logic [1:0] T_RIGHT = 2'b01;
    localparam logic [1:0] T_LEFT  = 2'b10;

    logic            CLOCK_50 = 1'b0;
    logic            reset, game_tick, run;
    logic [NP-1:0]   key_left, key_right;
    logic [2*NP-1:0] turn;
    logic [NP-1:0]   overflow;

    player_turn_queue #(
        .NUM_PLAYERS    (NP),
        .QUEUE_DEPTH    (QD),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .game_tick(game_tick),
        .run      (run),
        .key_left (key_left),
        .key_right(key_right),
        .turn     (turn),
        .overflow (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef logic [1:0] tq_t[$];
    tq_t          mq [NP];
    logic [1:0]   sb[$];
    logic [1:0]   last_exp [NP];
    logic [NP-1:0] exp_ovf;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input int p, input logic [1:0] d);
        if (!run || d == T_NONE) return;
        if (mq[p].size() < QD) mq[p].push_back(d);
        else exp_ovf[p] = 1'b1;
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            last_exp[p] = T_NONE;
        end
    endtask

    task automatic queue_tick_expect();
        for (int p = 0; p < NP; p++) begin
            logic [1:0] e;
            if (!run) e = T_NONE;
            else if (mq[p].size() > 0) e = mq[p].pop_front();
            else e = T_NONE;
            sb.push_back(e);
            last_exp[p] = e;
        end
    endtask

    task automatic check_tick_outputs();
        for (int p = 0; p < NP; p++) begin
            logic [1:0] e;
            e = sb.pop_front();
            check($sformatf("turn_p%0d", p), 32'(turn[2*p +: 2]), 32'(e));
        end
    endtask

    // Called at a negedge; returns at a negedge after the output is registered.
    task automatic do_tick();
        queue_tick_expect();
        game_tick = 1'b1;
        @(negedge CLOCK_50);
        game_tick = 1'b0;
        check_tick_outputs();
    endtask

    task automatic press(input int p, input logic l, input logic r);
        key_left[p]  = l;
        key_right[p] = r;
        model_push(p, (l && !r) ? T_LEFT : (r && !l) ? T_RIGHT : T_NONE);
        repeat (LAT + 1) @(negedge CLOCK_50);
        key_left[p]  = 1'b0;
        key_right[p] = 1'b0;
        repeat (LAT + 2) @(negedge CLOCK_50);
    endtask

    // Right press whose push lands on the same edge as a game_tick.
    task automatic press_right_with_tick(input int p);
        key_right[p] = 1'b1;
        repeat (LAT) @(negedge CLOCK_50);
        queue_tick_expect();
        model_push(p, T_RIGHT);
        game_tick = 1'b1;
        @(negedge CLOCK_50);
        game_tick = 1'b0;
        check_tick_outputs();
        key_right[p] = 1'b0;
        repeat (LAT + 2) @(negedge CLOCK_50);
    endtask

    initial begin
        reset = 1'b1; game_tick = 1'b0; run = 1'b0;
        key_left = '0; key_right = '0; exp_ovf = '0;
        model_clear();
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("reset_turn", 32'(turn), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);

        run = 1'b1;
        @(negedge CLOCK_50);
        // Single right press on player 0, then held output between ticks.
        press(0, 1'b0, 1'b1);
        do_tick();
        repeat (3) @(negedge CLOCK_50);
        check("turn_hold", 32'(turn), 32'({last_exp[2], last_exp[1], last_exp[0]}));
        do_tick();

        // Three left presses into a depth-2 queue.
        repeat (3) press(1, 1'b1, 1'b0);
        check("ovf_after_3", 32'(overflow), 32'(exp_ovf));
        repeat (3) do_tick();

        // Simultaneous left+right cancels.
        press(2, 1'b1, 1'b1);
        do_tick();
        check("ovf_both", 32'(overflow), 32'(exp_ovf));

        // Full queue plus press coinciding with a tick: no overflow.
        press(0, 1'b0, 1'b1);
        press(0, 1'b1, 1'b0);
        press_right_with_tick(0);
        check("ovf_coincide", 32'(overflow), 32'(exp_ovf));
        repeat (2) do_tick();
        do_tick();

`ifdef TURN_DEBOUNCE_EN
        // A pulse shorter than the debounce window is ignored.
        key_left[0] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        key_left[0] = 1'b0;
        repeat (LAT + 2) @(negedge CLOCK_50);
        press(0, 1'b1, 1'b0);
        do_tick();
        do_tick();
`endif

        // Reset with non-empty queues and a key held through it.
        press(0, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0);
        key_right[0] = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        model_clear();
        exp_ovf = '0;
        check("rst_mid_turn", 32'(turn), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        repeat (LAT + 4) @(negedge CLOCK_50);
        do_tick();
        key_right[0] = 1'b0;
        repeat (LAT + 2) @(negedge CLOCK_50);
        press(0, 1'b0, 1'b1);
        do_tick();

        // run=0 flushes, forces turn to zero, ignores ticks and presses.
        press(2, 1'b0, 1'b1);
        press(1, 1'b1, 1'b0);
        run = 1'b0;
        @(negedge CLOCK_50);
        model_clear();
        check("run0_turn", 32'(turn), 32'd0);
        do_tick();
        press(1, 1'b1, 1'b0);
        run = 1'b1;
        @(negedge CLOCK_50);
        do_tick();
        check("ovf_final", 32'(overflow), 32'(exp_ovf));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
